// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth sequential signed multiplier.
// One add/subtract plus one arithmetic right shift per clock, WIDTH steps per
// product. The start/ready handshake faces the ALU control; the product and its
// overflow flag stay on the outputs until the next product completes.
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  input  logic                 ctrl_start,
  output logic                 busy,
  output logic                 data_resultRDY,
  output logic [2*WIDTH-1:0]   result,
  output logic                 data_exception
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH:0]     r_m;       // multiplicand, sign-extended by one bit
  logic [WIDTH:0]     r_acc;     // one guard bit so -2^(WIDTH-1) cannot overflow
  logic [WIDTH-1:0]   r_q;
  logic               r_qm1;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_result;
  logic               r_exc;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_acc_next;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_qm1_next;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_high;    // bits that must all match for a WIDTH-bit fit
  logic               w_exc;
  logic               w_accept;
  logic               w_last_step;

  assign w_accept    = ctrl_start && (r_state != S_RUN);
  assign w_last_step = (r_state == S_RUN) && (r_count == CW'(WIDTH - 1));

  // Booth recoding of {Q[0], q_m1}, then the arithmetic shift of {acc, Q, q_m1}.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc + ~r_m + 1'b1;
      default: w_sum = r_acc;
    endcase
    w_acc_next = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q_next   = {w_sum[0], r_q[WIDTH-1:1]};
    w_qm1_next = r_q[0];
    w_product  = {w_acc_next[WIDTH-1:0], w_q_next};
    w_high     = w_product[2*WIDTH-1:WIDTH-1];
    w_exc      = !((&w_high) || !(|w_high));
  end

  // Control FSM and datapath registers, all cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    if (reset) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_RUN;
      r_m     <= {data_operandA[WIDTH-1], data_operandA};
      r_acc   <= '0;
      r_q     <= data_operandB;
      r_qm1   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_q     <= w_q_next;
          r_qm1   <= w_qm1_next;
          r_count <= r_count + CW'(1);
          if (w_last_step) begin
            r_result <= w_product;
            r_exc    <= w_exc;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (r_state == S_RUN);
  assign data_resultRDY = (r_state == S_DONE);
  assign result         = r_result;
  assign data_exception = r_exc;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and sweep bench for booth_seq_multiplier at WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_booth_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data_operandA;
  logic [7:0]  data_operandB;
  logic        ctrl_start;
  logic        busy;
  logic        data_resultRDY;
  logic [15:0] result;
  logic        data_exception;

  int total = 0;
  int bad   = 0;

  booth_seq_multiplier #(.WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_start     (ctrl_start),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .result         (result),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  // Issue one operation from IDLE/DONE (called at a falling edge) and wait for RDY.
  // lat counts falling edges from the one after the accept edge until RDY is seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic e,
                       output int lat, output int bz);
    data_operandA = a;
    data_operandB = b;
    ctrl_start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b0;
    lat = 0;
    bz  = 0;
    while (!data_resultRDY && lat < 40) begin
      if (busy) bz++;
      @(negedge clock);
      lat++;
    end
    r = result;
    e = data_exception;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_start = 1'b0;
    data_operandA = 8'h00;
    data_operandB = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({busy, data_resultRDY, data_exception, result} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b exc=%b result=%h, want all zero",
               busy, data_resultRDY, data_exception, result);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b rdy=%b, want 0 0", busy, data_resultRDY);
    end
  endtask

  task automatic test_basic();
    logic [15:0] r;
    logic e;
    int lat, bz;
    do_op(8'd3, 8'd5, r, e, lat, bz);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles, want 8", lat);
    end
    total++;
    if (bz !== 8) begin
      bad++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", bz);
    end
    total++;
    if (r !== 16'h000F || e !== 1'b0) begin
      bad++;
      $display("FAIL basic_3x5: got %h exc=%b, want 000f exc=0", r, e);
    end
    @(negedge clock);
    total++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0 || result !== 16'h000F) begin
      bad++;
      $display("FAIL basic_rdy_one_cycle: got rdy=%b busy=%b result=%h, want 0 0 000f",
               data_resultRDY, busy, result);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        e;
  } vec_t;

  task automatic test_signed();
    vec_t v[4];
    logic [15:0] r;
    logic e;
    int lat, bz;
    v[0] = '{8'hF9, 8'h06, 16'hFFD6, 1'b0};
    v[1] = '{8'h7F, 8'h7F, 16'h3F01, 1'b1};
    v[2] = '{8'h80, 8'h80, 16'h4000, 1'b1};
    v[3] = '{8'h80, 8'h01, 16'hFF80, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].a, v[i].b, r, e, lat, bz);
      total++;
      if (r !== v[i].p || e !== v[i].e || lat !== 8) begin
        bad++;
        $display("FAIL signed_vec%0d: got %h exc=%b lat=%0d, want %h exc=%b lat=8",
                 i, r, e, lat, v[i].p, v[i].e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int held_bad;
    data_operandA = 8'd3;
    data_operandB = 8'd5;
    ctrl_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b0;
    lat = 0;
    while (!data_resultRDY && lat < 40) begin
      if (lat == 3) begin
        data_operandA = 8'd2;
        data_operandB = 8'd2;
        ctrl_start = 1'b1;
      end else begin
        ctrl_start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    total++;
    if (result !== 16'h000F || lat !== 8) begin
      bad++;
      $display("FAIL ignore_start_in_run: got %h lat=%0d, want 000f lat=8", result, lat);
    end
    // Start again in the DONE cycle.
    ctrl_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b0;
    data_operandA = 8'h55;
    data_operandB = 8'hAA;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_in_done_busy: got busy=%b, want 1", busy);
    end
    lat = 0;
    held_bad = 0;
    while (!data_resultRDY && lat < 40) begin
      if (result !== 16'h000F) held_bad++;
      @(negedge clock);
      lat++;
    end
    total++;
    if (held_bad !== 0) begin
      bad++;
      $display("FAIL result_held: got %0d cycles with result changed, want 0", held_bad);
    end
    total++;
    if (result !== 16'h0004 || data_exception !== 1'b0 || lat !== 8) begin
      bad++;
      $display("FAIL back_to_back_2x2: got %h exc=%b lat=%0d, want 0004 exc=0 lat=8",
               result, data_exception, lat);
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] r;
    logic e;
    int lat, bz;
    int rdy_seen;
    data_operandA = 8'd3;
    data_operandB = 8'd5;
    ctrl_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0 || result !== 16'h0000 ||
        data_exception !== 1'b0) begin
      bad++;
      $display("FAIL reset_midrun: got busy=%b rdy=%b result=%h exc=%b, want 0 0 0000 0",
               busy, data_resultRDY, result, data_exception);
    end
    rdy_seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (data_resultRDY || busy) rdy_seen++;
    end
    total++;
    if (rdy_seen !== 0) begin
      bad++;
      $display("FAIL no_rdy_after_reset: got %0d active cycles, want 0", rdy_seen);
    end
    do_op(8'd4, 8'hFD, r, e, lat, bz);
    total++;
    if (r !== 16'hFFF4 || e !== 1'b0 || lat !== 8) begin
      bad++;
      $display("FAIL after_reset_4xm3: got %h exc=%b lat=%0d, want fff4 exc=0 lat=8", r, e, lat);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] corner[7];
    logic [7:0] a, b;
    logic [15:0] r;
    logic e;
    int lat, bz;
    int sa, sb, p;
    logic exp_e;
    corner = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h81, 8'h80, 8'h02};
    for (int n = 0; n < 1009; n++) begin
      if (n < 49) begin
        a = corner[n / 7];
        b = corner[n % 7];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      sa = $signed(a);
      sb = $signed(b);
      p = sa * sb;
      exp_e = (p > 127) || (p < -128);
      do_op(a, b, r, e, lat, bz);
      total++;
      if (r !== 16'(p) || e !== exp_e || lat !== 8) begin
        bad++;
        $display("FAIL sweep a=%h b=%h: got %h exc=%b lat=%0d, want %h exc=%b lat=8",
                 a, b, r, e, lat, 16'(p), exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
